// File: rtl/bus_timer.sv
// bus_timer -- memory-mapped machine timer (mtime / mtimecmp / msip).
//
// A single-slave window on the memory controller's external bus. It provides
// a free-running 64-bit mtime counter advanced every PRESCALE clocks, one
// 64-bit mtimecmp per hart, and a registered timer-interrupt output per hart.
//
// Optional feature macro: TIMER_MSIP_EN. When defined, per-hart msip bits live
// at offset 0x0000+4h and drive o_sip. When undefined, that region reads 0,
// ignores writes, and o_sip is tied low.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_bus_en          access request, held stable until o_ack is seen
//   i_wr_en           1 = write, 0 = read
//   i_addr            byte address (bits [1:0] ignored)
//   i_wr_data         write data
//   i_byte_en         write byte lanes
//   o_ack             one-cycle completion pulse
//   o_rd_data         read data, nonzero only while o_ack is high
//   o_tip             per-hart timer interrupt pending (registered)
//   o_sip             per-hart software interrupt pending
module bus_timer #(
  parameter int          HARTS    = 2,
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bus_en,
  input  logic             i_wr_en,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wr_data,
  input  logic [3:0]       i_byte_en,
  output logic             o_ack,
  output logic [31:0]      o_rd_data,
  output logic [HARTS-1:0] o_tip,
  output logic [HARTS-1:0] o_sip
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int              PS_W    = $clog2(PRESCALE) + 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Replace the byte lanes of old_word selected by be with the new data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return res;
  endfunction

  logic [1:0]      state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q [HARTS];
  logic [63:0]     mtimecmp_d [HARTS];
  logic [HARTS-1:0] tip_q, tip_d;

  // Address decode; only i_addr[15:2] selects a register inside the window.
  logic        hit_s, acc_s, wr_s, tick_s;
  logic        sel_mtime_lo_s, sel_mtime_hi_s, sel_cmp_s, cmp_hi_s;
  logic [10:0] cmp_idx_s;
  logic [31:0] rd_val_s;
  logic [1:0]  unused_addr_s;

  assign unused_addr_s  = i_addr[1:0];
  assign hit_s          = (i_addr[31:16] == BASE[31:16]);
  assign acc_s          = (state_q == ST_IDLE) && i_bus_en && hit_s;
  assign wr_s           = acc_s && i_wr_en;
  assign sel_mtime_lo_s = (i_addr[15:2] == 14'h2FFE);
  assign sel_mtime_hi_s = (i_addr[15:2] == 14'h2FFF);
  assign sel_cmp_s      = (i_addr[15:14] == 2'b01);
  assign cmp_idx_s      = i_addr[13:3];
  assign cmp_hi_s       = i_addr[2];

`ifdef TIMER_MSIP_EN
  logic [HARTS-1:0] msip_q, msip_d;
  logic             sel_msip_s;
  logic [11:0]      msip_idx_s;

  assign sel_msip_s = (i_addr[15:14] == 2'b00);
  assign msip_idx_s = i_addr[13:2];
  assign o_sip      = msip_q;

  // msip update: only lane 0 carries the single implemented bit.
  always_comb begin
    msip_d = msip_q;
    for (int h = 0; h < HARTS; h++) begin
      if (wr_s && sel_msip_s && i_byte_en[0] && (int'({20'd0, msip_idx_s}) == h)) begin
        msip_d[h] = i_wr_data[0];
      end else begin
        msip_d[h] = msip_q[h];
      end
    end
  end
`else
  assign o_sip = {HARTS{1'b0}};
`endif

  // Prescaler: mtime advances on the cycle the counter wraps.
  always_comb begin
    if (ps_q == PS_LAST) begin
      ps_d   = {PS_W{1'b0}};
      tick_s = 1'b1;
    end else begin
      ps_d   = ps_q + {{(PS_W-1){1'b0}}, 1'b1};
      tick_s = 1'b0;
    end
  end

  // mtime next value: a bus write wins over the increment for that cycle.
  always_comb begin
    if (wr_s && sel_mtime_lo_s) begin
      mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], i_wr_data, i_byte_en)};
    end else if (wr_s && sel_mtime_hi_s) begin
      mtime_d = {merge_lanes(mtime_q[63:32], i_wr_data, i_byte_en), mtime_q[31:0]};
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
  end

  // mtimecmp writes and the compare that feeds the registered o_tip.
  always_comb begin
    for (int h = 0; h < HARTS; h++) begin
      if (wr_s && sel_cmp_s && (int'({21'd0, cmp_idx_s}) == h)) begin
        if (cmp_hi_s) begin
          mtimecmp_d[h] = {merge_lanes(mtimecmp_q[h][63:32], i_wr_data, i_byte_en),
                           mtimecmp_q[h][31:0]};
        end else begin
          mtimecmp_d[h] = {mtimecmp_q[h][63:32],
                           merge_lanes(mtimecmp_q[h][31:0], i_wr_data, i_byte_en)};
        end
      end else begin
        mtimecmp_d[h] = mtimecmp_q[h];
      end
      tip_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  // Read mux; unmapped offsets inside the window return 0.
  always_comb begin
    rd_val_s = 32'd0;
    if (sel_mtime_lo_s) begin
      rd_val_s = mtime_q[31:0];
    end else if (sel_mtime_hi_s) begin
      rd_val_s = mtime_q[63:32];
    end else if (sel_cmp_s) begin
      for (int h = 0; h < HARTS; h++) begin
        if (int'({21'd0, cmp_idx_s}) == h) begin
          rd_val_s = cmp_hi_s ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
        end else begin
          rd_val_s = rd_val_s;
        end
      end
`ifdef TIMER_MSIP_EN
    end else if (sel_msip_s) begin
      for (int h = 0; h < HARTS; h++) begin
        if (int'({20'd0, msip_idx_s}) == h) begin
          rd_val_s = {31'd0, msip_q[h]};
        end else begin
          rd_val_s = rd_val_s;
        end
      end
`endif
    end else begin
      rd_val_s = 32'd0;
    end
  end

  // Handshake FSM: HOLD swallows a request still asserted after its ack.
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    rd_data_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (acc_s) begin
          state_d   = ST_RESP;
          ack_d     = 1'b1;
          rd_data_d = i_wr_en ? 32'd0 : rd_val_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        state_d = i_bus_en ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        state_d = i_bus_en ? ST_HOLD : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      rd_data_q <= 32'd0;
      ps_q      <= {PS_W{1'b0}};
      mtime_q   <= 64'd0;
      tip_q     <= {HARTS{1'b0}};
      for (int h = 0; h < HARTS; h++) begin
        mtimecmp_q[h] <= {64{1'b1}};
      end
`ifdef TIMER_MSIP_EN
      msip_q    <= {HARTS{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
      ps_q      <= ps_d;
      mtime_q   <= mtime_d;
      tip_q     <= tip_d;
      for (int h = 0; h < HARTS; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
`ifdef TIMER_MSIP_EN
      msip_q    <= msip_d;
`endif
    end
  end

  assign o_ack     = ack_q;
  assign o_rd_data = rd_data_q;
  assign o_tip     = tip_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed testbench for bus_timer: a PRESCALE=1 instance carries most of the
// sequence, and a PRESCALE=4 instance checks the prescaled count after reset.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;

  logic        bus_en = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = 32'd0, wr_data = 32'd0;
  logic [3:0]  byte_en = 4'd0;
  logic        ack;
  logic [31:0] rd_data;
  logic [1:0]  tip, sip;

  logic        b4_bus_en = 1'b0;
  logic [31:0] b4_addr = 32'd0;
  logic        b4_ack;
  logic [31:0] b4_rd_data;
  logic [1:0]  b4_tip, b4_sip;

  bus_timer #(.HARTS(2), .BASE(BASE), .PRESCALE(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_bus_en(bus_en), .i_wr_en(wr_en),
    .i_addr(addr), .i_wr_data(wr_data), .i_byte_en(byte_en),
    .o_ack(ack), .o_rd_data(rd_data), .o_tip(tip), .o_sip(sip)
  );

  bus_timer #(.HARTS(2), .BASE(BASE), .PRESCALE(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(b4_bus_en), .i_wr_en(1'b0),
    .i_addr(b4_addr), .i_wr_data(32'd0), .i_byte_en(4'd0),
    .o_ack(b4_ack), .o_rd_data(b4_rd_data), .o_tip(b4_tip), .o_sip(b4_sip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the PRESCALE=1 instance; ends one cycle after the ack with
  // i_bus_en low, so the next access can start immediately.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rdata, output int acc_cyc);
    int n;
    bus_en = 1'b1; wr_en = wr; addr = a; wr_data = d; byte_en = be;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 20);
    check("xfer_ack", 64'(ack), 64'd1);
    rdata   = rd_data;
    acc_cyc = cyc;
    bus_en = 1'b0; wr_en = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    int          t0;
    int          bad;
    int          acks;
    logic [31:0] exp_msip_rd;
    logic [1:0]  exp_sip;

    // Reset state.
    tick();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_tip", 64'(tip), 64'd0);
    check("rst_sip", 64'(sip), 64'd0);
    rst = 1'b0;

    // PRESCALE=4: 40 idle cycles give mtime = 10.
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b4_ack !== 1'b0 || b4_tip !== 2'b00) bad++;
    end
    check("ps4_idle_quiet", 64'(bad), 64'd0);
    b4_bus_en = 1'b1; b4_addr = BASE + 32'hBFF8;
    tick();
    check("ps4_ack", 64'(b4_ack), 64'd1);
    check("ps4_mtime_lo", 64'(b4_rd_data), 64'd10);
    b4_bus_en = 1'b0;
    tick();
    check("ps4_rd_data_idle", 64'(b4_rd_data), 64'd0);
    b4_bus_en = 1'b1; b4_addr = BASE + 32'hBFFC;
    tick();
    check("ps4_mtime_hi", 64'(b4_rd_data), 64'd0);
    b4_bus_en = 1'b0;
    tick();

    // Timer interrupt rises one cycle after mtime reaches mtimecmp[1].
    xfer(1'b1, BASE + 32'hBFF8, 32'h0000_0010, 4'hF, rd, t0);
    xfer(1'b1, BASE + 32'h4008, 32'h0000_0020, 4'hF, rd, bad);
    xfer(1'b1, BASE + 32'h400C, 32'h0000_0000, 4'hF, rd, bad);
    while (cyc < t0 + 16) tick();
    check("tip1_before", 64'(tip[1]), 64'd0);
    tick();
    check("tip1_rise", 64'(tip[1]), 64'd1);
    check("tip0_low", 64'(tip[0]), 64'd0);

    // Raising mtimecmp[1] drops o_tip[1] two cycles after the request.
    bus_en = 1'b1; wr_en = 1'b1; addr = BASE + 32'h4008; wr_data = 32'hFFFF_FFFF; byte_en = 4'hF;
    tick();
    check("cmp_wr_ack", 64'(ack), 64'd1);
    check("tip1_still_high", 64'(tip[1]), 64'd1);
    bus_en = 1'b0; wr_en = 1'b0;
    tick();
    check("tip1_fall", 64'(tip[1]), 64'd0);

    // Low-word write followed by the full 64-bit carry.
    xfer(1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, bad);
    xfer(1'b0, BASE + 32'hBFF8, 32'd0, 4'h0, rd, bad);
    check("wrap_lo", 64'(rd), 64'd0);
    xfer(1'b0, BASE + 32'hBFFC, 32'd0, 4'h0, rd, bad);
    check("wrap_hi", 64'(rd), 64'd1);

    // Byte-lane write into mtimecmp[0] low.
    xfer(1'b1, BASE + 32'h4000, 32'hAABB_CCDD, 4'b0010, rd, bad);
    xfer(1'b0, BASE + 32'h4000, 32'd0, 4'h0, rd, bad);
    check("cmp0_lane1", 64'(rd), 64'hFFFF_CCFF);

    // Outside the window: never acknowledged.
    bus_en = 1'b1; wr_en = 1'b0; addr = 32'h0300_BFF8;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    check("miss_no_ack", 64'(acks), 64'd0);
    bus_en = 1'b0;
    tick();

    // Unmapped offset inside the window: acked, reads 0.
    xfer(1'b0, BASE + 32'h8000, 32'd0, 4'h0, rd, bad);
    check("unmapped_rd", 64'(rd), 64'd0);

    // Request held 5 cycles past its ack produces a single pulse.
    bus_en = 1'b1; wr_en = 1'b0; addr = BASE + 32'hBFFC;
    acks = 0;
    bad = 0;
    while (ack !== 1'b1 && bad < 20) begin
      tick();
      bad++;
    end
    if (ack === 1'b1) acks++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    check("hold_single_ack", 64'(acks), 64'd1);
    bus_en = 1'b0;
    tick();
    tick();

    // Software interrupt bit for hart 1.
`ifdef TIMER_MSIP_EN
    exp_sip = 2'b10;
    exp_msip_rd = 32'd1;
`else
    exp_sip = 2'b00;
    exp_msip_rd = 32'd0;
`endif
    xfer(1'b1, BASE + 32'h0004, 32'h0000_0001, 4'b0001, rd, bad);
    check("msip_sip", 64'(sip), 64'(exp_sip));
    xfer(1'b0, BASE + 32'h0004, 32'd0, 4'h0, rd, bad);
    check("msip_rd", 64'(rd), 64'(exp_msip_rd));

    // Reset during RESP drops the ack and restores register reset values.
    bus_en = 1'b1; wr_en = 1'b0; addr = BASE + 32'hBFF8;
    bad = 0;
    while (ack !== 1'b1 && bad < 20) begin
      tick();
      bad++;
    end
    check("pre_rst_ack", 64'(ack), 64'd1);
    rst = 1'b1;
    bus_en = 1'b0;
    #1;
    check("rst_mid_ack", 64'(ack), 64'd0);
    check("rst_mid_rd_data", 64'(rd_data), 64'd0);
    check("rst_mid_sip", 64'(sip), 64'd0);
    tick();
    rst = 1'b0;
    xfer(1'b0, BASE + 32'hBFF8, 32'd0, 4'h0, rd, bad);
    check("post_rst_mtime", 64'(rd), 64'd0);
    xfer(1'b0, BASE + 32'h4000, 32'd0, 4'h0, rd, bad);
    check("post_rst_cmp0_lo", 64'(rd), 64'hFFFF_FFFF);
    xfer(1'b0, BASE + 32'h400C, 32'd0, 4'h0, rd, bad);
    check("post_rst_cmp1_hi", 64'(rd), 64'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
